usb_cdc_serial_state_notify: RTL and testbench

- Device-side transmitter of the CDC-ACM SERIAL_STATE notification on the interrupt IN endpoint. It is the device-to-host counterpart of the endpoint-0 line-coding/control-line request decoder.
- Watches UART status (DCD/DSR levels and one-shot error/break/ring events), builds the 10-byte notification packet and feeds it to the USB device controller byte-by-byte on usb_txpop.
- Sits beside the UART1 bridge; uart_en_i comes from the decoded DTR bit.

---
 rtl/usb_cdc_serial_state_notify_if.sv | 28 ++
 rtl/usb_cdc_serial_state_notify.sv | 187 ++++++++++++++++++
 tb/tb_usb_cdc_serial_state_notify.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/usb_cdc_serial_state_notify_if.sv
`default_nettype none
// ============================================================================
//  Module      : usb_cdc_serial_state_notify_if
//  Description : Interrupt IN endpoint handshake between the USB device
//                controller (master) and the SERIAL_STATE notifier (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface usb_cdc_serial_state_notify_if;
  logic [3:0]  endpt_sel;
  logic        usb_txact;
  logic        usb_txpop;
  logic [7:0]  usb_txdat_o;
  logic [11:0] usb_txdat_len_o;
  logic        notify_pending_o;

  // Controller side: selects the endpoint and pops bytes
  modport master (
    output endpt_sel, usb_txact, usb_txpop,
    input  usb_txdat_o, usb_txdat_len_o, notify_pending_o
  );

  // Notifier side: presents packet bytes and the armed flag
  modport slave (
    input  endpt_sel, usb_txact, usb_txpop,
    output usb_txdat_o, usb_txdat_len_o, notify_pending_o
  );
endinterface
`default_nettype wire

// File: rtl/usb_cdc_serial_state_notify.sv
`default_nettype none
// ============================================================================
//  Module      : usb_cdc_serial_state_notify
//  Description : CDC-ACM SERIAL_STATE notification transmitter. Collects UART
//                line levels and one-shot events, builds the 10-byte packet
//                and serves it byte-by-byte on the interrupt IN endpoint.
//                Optional macro SERIAL_STATE_HOLDOFF_EN enforces a minimum
//                gap of HOLDOFF_CYCLES between notifications.
//  Revision    : 1.0 - initial release
// ============================================================================
module usb_cdc_serial_state_notify #(
  parameter logic [3:0]  NOTIFY_ENDPT   = 4'h9,
  parameter logic [15:0] INTERFACE_NUM  = 16'd0,
  parameter logic [15:0] HOLDOFF_CYCLES = 16'd1000
) (
  input  wire logic                   PHY_CLKOUT,
  input  wire logic                   RESET_IN,
  input  wire logic                   uart_en_i,
  input  wire logic                   dcd_i,
  input  wire logic                   dsr_i,
  input  wire logic                   break_evt_i,
  input  wire logic                   ring_evt_i,
  input  wire logic                   framing_err_i,
  input  wire logic                   parity_err_i,
  input  wire logic                   overrun_err_i,
  usb_cdc_serial_state_notify_if.slave usb,
  output logic                        notify_sent_o,
  output logic [15:0]                 serial_state_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_SEND  = 2'd2
  } state_t;

  localparam logic [3:0] c_LAST_IDX = 4'd10;

  state_t      r_state, w_state_nxt;
  logic [3:0]  r_idx;
  logic [7:0]  r_snapshot;
  logic [7:0]  r_sticky;
  logic [1:0]  r_rep_lvl;
  logic        r_force;
  logic        r_uart_en_d;
  logic        r_sent;
  logic [15:0] r_serial_state;

  logic [7:0]  w_pulses;
  logic [1:0]  w_lvl;
  logic        w_rise;
  logic        w_arm;
  logic        w_take;
  logic        w_done;
  logic        w_retry;
  logic        w_holdoff_busy;

  // Event pulses placed directly at their bitmap positions (bits 6..2)
  assign w_pulses = {1'b0, overrun_err_i, parity_err_i, framing_err_i,
                     ring_evt_i, break_evt_i, 2'b00};
  assign w_lvl    = {dsr_i, dcd_i};
  assign w_rise   = uart_en_i & ~r_uart_en_d;
  assign w_arm    = uart_en_i & ~w_holdoff_busy &
                    (((r_sticky | w_pulses) != 8'h00) || (w_lvl != r_rep_lvl) || r_force);

`ifdef SERIAL_STATE_HOLDOFF_EN
  logic [15:0] r_holdoff;

  // Minimum-gap counter, restarted by every completed notification
  always_ff @(posedge PHY_CLKOUT) begin
    if (RESET_IN) begin
      r_holdoff <= 16'd0;
    end else if (w_done) begin
      r_holdoff <= HOLDOFF_CYCLES;
    end else if (r_holdoff != 16'd0) begin
      r_holdoff <= r_holdoff - 16'd1;
    end
  end

  assign w_holdoff_busy = (r_holdoff != 16'd0);
`else
  // Without the gap counter the parameter has no effect
  assign w_holdoff_busy = 1'b0 & (HOLDOFF_CYCLES != 16'd0);
`endif

  // State register
  always_ff @(posedge PHY_CLKOUT) begin
    if (RESET_IN) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next-state decode and transfer outcome strobes
  always_comb begin
    w_state_nxt = r_state;
    w_take      = 1'b0;
    w_done      = 1'b0;
    w_retry     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_arm) begin
          w_take      = 1'b1;
          w_state_nxt = S_ARMED;
        end
      end
      S_ARMED: begin
        if (!uart_en_i) begin
          w_state_nxt = S_IDLE;
        end else if (usb.usb_txact && (usb.endpt_sel == NOTIFY_ENDPT)) begin
          w_state_nxt = S_SEND;
        end
      end
      S_SEND: begin
        // A short or aborted transfer re-arms the same snapshot
        if (!usb.usb_txact) begin
          if (r_idx == c_LAST_IDX) begin
            w_done      = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_retry     = 1'b1;
            w_state_nxt = S_ARMED;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Event accumulation, snapshot capture, byte index and reporting registers
  always_ff @(posedge PHY_CLKOUT) begin
    if (RESET_IN) begin
      r_idx          <= 4'd0;
      r_snapshot     <= 8'h00;
      r_sticky       <= 8'h00;
      r_rep_lvl      <= 2'b00;
      r_force        <= 1'b0;
      r_uart_en_d    <= 1'b0;
      r_sent         <= 1'b0;
      r_serial_state <= 16'h0000;
    end else begin
      r_uart_en_d <= uart_en_i;
      r_sent      <= w_done;

      if (!uart_en_i || w_take) r_sticky <= 8'h00;
      else                      r_sticky <= r_sticky | w_pulses;

      if (w_take)      r_force <= 1'b0;
      else if (w_rise) r_force <= 1'b1;

      if (w_take) begin
        r_snapshot <= r_sticky | w_pulses | {6'b000000, w_lvl};
      end

      if (w_take || w_retry) begin
        r_idx <= 4'd0;
      end else if ((r_state == S_SEND) && usb.usb_txact && usb.usb_txpop &&
                   (r_idx != c_LAST_IDX)) begin
        r_idx <= r_idx + 4'd1;
      end

      if (w_done) begin
        r_rep_lvl      <= r_snapshot[1:0];
        r_serial_state <= {8'h00, r_snapshot};
      end
    end
  end

  // Packet byte mux
  always_comb begin
    usb.usb_txdat_o = 8'h00;
    case (r_idx)
      4'd0:    usb.usb_txdat_o = 8'hA1;
      4'd1:    usb.usb_txdat_o = 8'h20;
      4'd4:    usb.usb_txdat_o = INTERFACE_NUM[7:0];
      4'd5:    usb.usb_txdat_o = INTERFACE_NUM[15:8];
      4'd6:    usb.usb_txdat_o = 8'h02;
      4'd8:    usb.usb_txdat_o = r_snapshot;
      default: usb.usb_txdat_o = 8'h00;
    endcase
  end

  assign usb.usb_txdat_len_o  = 12'd10;
  assign usb.notify_pending_o = (r_state != S_IDLE);
  assign notify_sent_o        = r_sent;
  assign serial_state_o       = r_serial_state;

endmodule
`default_nettype wire

// File: tb/tb_usb_cdc_serial_state_notify.sv
`default_nettype none
// ============================================================================
//  Module      : tb_usb_cdc_serial_state_notify
//  Description : Self-checking bench for the SERIAL_STATE notifier. Expected
//                packets come from a packet-layout function and a simple
//                event/level model of what the host should be told.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_usb_cdc_serial_state_notify;

  localparam logic [15:0] IFN = 16'h0302;

  logic PHY_CLKOUT = 1'b0;
  logic RESET_IN;
  logic uart_en_i, dcd_i, dsr_i;
  logic break_evt_i, ring_evt_i, framing_err_i, parity_err_i, overrun_err_i;
  logic        notify_sent_o;
  logic [15:0] serial_state_o;

  usb_cdc_serial_state_notify_if bus ();

  usb_cdc_serial_state_notify #(
    .NOTIFY_ENDPT   (4'h9),
    .INTERFACE_NUM  (IFN),
    .HOLDOFF_CYCLES (16'd20)
  ) dut (
    .PHY_CLKOUT     (PHY_CLKOUT),
    .RESET_IN       (RESET_IN),
    .uart_en_i      (uart_en_i),
    .dcd_i          (dcd_i),
    .dsr_i          (dsr_i),
    .break_evt_i    (break_evt_i),
    .ring_evt_i     (ring_evt_i),
    .framing_err_i  (framing_err_i),
    .parity_err_i   (parity_err_i),
    .overrun_err_i  (overrun_err_i),
    .usb            (bus),
    .notify_sent_o  (notify_sent_o),
    .serial_state_o (serial_state_o)
  );

  always #5 PHY_CLKOUT = ~PHY_CLKOUT;

  int n_chk  = 0;
  int n_fail = 0;

  // Host-visible model: accumulated events, last reported levels, expected bitmap
  logic [7:0] m_sticky = 8'h00;
  logic [7:0] m_exp    = 8'h00;
  logic [1:0] m_rep    = 2'b00;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] pkt_byte(input int i, input logic [7:0] bm);
    logic [7:0] p [10];
    p = '{8'hA1, 8'h20, 8'h00, 8'h00, IFN[7:0], IFN[15:8], 8'h02, 8'h00, bm, 8'h00};
    return (i < 10) ? p[i] : 8'h00;
  endfunction

  task automatic set_pulses(input logic [7:0] m);
    {overrun_err_i, parity_err_i, framing_err_i, ring_evt_i, break_evt_i} = m[6:2];
    if (uart_en_i) m_sticky = m_sticky | (m & 8'h7C);
  endtask

  // One-cycle event pulse; returns at the following negedge
  task automatic pulse(input logic [7:0] m);
    set_pulses(m);
    @(negedge PHY_CLKOUT);
    set_pulses(8'h00);
  endtask

  task automatic wait_pending(input string tag);
    int k = 0;
    while (bus.notify_pending_o !== 1'b1 && k < 200) begin
      @(negedge PHY_CLKOUT);
      k++;
    end
    chk({tag, "_pend"}, 16'(bus.notify_pending_o), 16'h1);
    m_exp    = m_sticky | {6'b000000, dsr_i, dcd_i};
    m_sticky = 8'h00;
  endtask

  // Host IN transfer with npops pops; optional event injected at pop 3
  task automatic xfer(input string tag, input int npops, input bit complete, input logic [7:0] inj);
    bus.endpt_sel = 4'h9;
    bus.usb_txact = 1'b1;
    @(negedge PHY_CLKOUT);
    for (int i = 0; i < npops; i++) begin
      chk($sformatf("%s_b%0d", tag, i), 16'(bus.usb_txdat_o), 16'(pkt_byte(i, m_exp)));
      bus.usb_txpop = 1'b1;
      if (i == 3) set_pulses(inj);
      @(negedge PHY_CLKOUT);
      bus.usb_txpop = 1'b0;
      set_pulses(8'h00);
    end
    chk({tag, "_tail"}, 16'(bus.usb_txdat_o), 16'(pkt_byte(npops, m_exp)));
    bus.usb_txact = 1'b0;
    @(negedge PHY_CLKOUT);
    if (complete) begin
      chk({tag, "_sent"}, 16'(notify_sent_o), 16'h1);
      chk({tag, "_state"}, serial_state_o, {8'h00, m_exp});
      chk({tag, "_idle"}, 16'(bus.notify_pending_o), 16'h0);
      m_rep = m_exp[1:0];
      @(negedge PHY_CLKOUT);
      chk({tag, "_sent_end"}, 16'(notify_sent_o), 16'h0);
    end else begin
      chk({tag, "_rearm"}, 16'(bus.notify_pending_o), 16'h1);
      chk({tag, "_idx0"}, 16'(bus.usb_txdat_o), 16'hA1);
      chk({tag, "_nosent"}, 16'(notify_sent_o), 16'h0);
    end
  endtask

  initial begin
    logic [7:0] msk;
    logic [1:0] lvl;
    int         cyc;

    RESET_IN = 1'b1;
    uart_en_i = 1'b0; dcd_i = 1'b0; dsr_i = 1'b0;
    set_pulses(8'h00);
    bus.endpt_sel = 4'h0; bus.usb_txact = 1'b0; bus.usb_txpop = 1'b0;
    repeat (3) @(negedge PHY_CLKOUT);
    RESET_IN = 1'b0;
    @(negedge PHY_CLKOUT);

    // Reset state
    chk("rst_dat", 16'(bus.usb_txdat_o), 16'hA1);
    chk("rst_len", 16'(bus.usb_txdat_len_o), 16'd10);
    chk("rst_pend", 16'(bus.notify_pending_o), 16'h0);
    chk("rst_sent", 16'(notify_sent_o), 16'h0);
    chk("rst_state", serial_state_o, 16'h0000);

    // Enable rising edge forces a levels-only report
    uart_en_i = 1'b1;
    wait_pending("force0");
    xfer("force0", 10, 1'b1, 8'h00);

    // Framing error
    pulse(8'h10);
`ifndef SERIAL_STATE_HOLDOFF_EN
    chk("frm_next", 16'(bus.notify_pending_o), 16'h1);
`endif
    wait_pending("frm");
    xfer("frm", 10, 1'b1, 8'h00);

    // DCD rises, then holds: exactly one report
    dcd_i = 1'b1;
    wait_pending("dcd");
    xfer("dcd", 10, 1'b1, 8'h00);
    repeat (5) @(negedge PHY_CLKOUT);
    chk("dcd_hold", 16'(bus.notify_pending_o), 16'h0);

    // Random error, wrong endpoint ignored, abort after 4 pops, retransmit
    msk = 8'h04 << 2'($urandom_range(0, 3));
    pulse(msk);
    wait_pending("abort");
    bus.endpt_sel = 4'h3; bus.usb_txact = 1'b1; bus.usb_txpop = 1'b1;
    @(negedge PHY_CLKOUT);
    bus.usb_txact = 1'b0; bus.usb_txpop = 1'b0;
    chk("wrong_ep", 16'(bus.usb_txdat_o), 16'hA1);
    xfer("abort", 4, 1'b0, 8'h00);
    dsr_i = 1'b1;
    @(negedge PHY_CLKOUT);
    dsr_i = 1'b0;
    xfer("retx", 11, 1'b1, 8'h00);
    repeat (4) @(negedge PHY_CLKOUT);
    chk("toggle_back", 16'(bus.notify_pending_o), 16'h0);

    // Overrun during a parity packet goes into the next packet
    pulse(8'h20);
    wait_pending("par");
    xfer("par", 10, 1'b1, 8'h40);
    wait_pending("ovr");
    xfer("ovr", 10, 1'b1, 8'h00);

    // Disabled: break ignored; re-enable forces levels-only report
    uart_en_i = 1'b0;
    m_sticky  = 8'h00;
    lvl = 2'($urandom_range(0, 3));
    {dsr_i, dcd_i} = lvl;
    pulse(8'h04);
    repeat (2) @(negedge PHY_CLKOUT);
    chk("dis_pend", 16'(bus.notify_pending_o), 16'h0);
    uart_en_i = 1'b1;
    wait_pending("reen");
    xfer("reen", 10, 1'b1, 8'h00);

    // Enable drops while armed: pending clears next cycle
    pulse(8'h08);
    wait_pending("drop");
    uart_en_i = 1'b0;
    @(negedge PHY_CLKOUT);
    chk("drop_pend", 16'(bus.notify_pending_o), 16'h0);
    m_sticky  = 8'h00;
    uart_en_i = 1'b1;
    wait_pending("drop_force");
    xfer("drop_force", 10, 1'b1, 8'h00);

    // Ring 5 cycles after notify_sent (sent was seen one negedge ago)
    cyc = 1;
    repeat (4) @(negedge PHY_CLKOUT);
    cyc += 4;
    pulse(8'h08);
    cyc += 1;
`ifdef SERIAL_STATE_HOLDOFF_EN
    while (bus.notify_pending_o !== 1'b1 && cyc < 200) begin
      @(negedge PHY_CLKOUT);
      cyc++;
    end
    chk("holdoff_gap", 16'(cyc >= 20 && cyc < 200), 16'h1);
`else
    chk("no_holdoff", 16'(bus.notify_pending_o), 16'h1);
`endif
    wait_pending("ring");
    xfer("ring", 10, 1'b1, 8'h00);

    // Randomized events and level changes
    for (int it = 0; it < 6; it++) begin
      msk = 8'($urandom) & 8'h7C;
      if ($urandom_range(0, 2) == 0) msk = 8'h00;
      lvl = 2'($urandom_range(0, 3));
      {dsr_i, dcd_i} = lvl;
      pulse(msk);
      if (msk != 8'h00 || lvl != m_rep) begin
        wait_pending($sformatf("rnd%0d", it));
        xfer($sformatf("rnd%0d", it), 10, 1'b1, 8'h00);
      end else begin
        repeat (3) @(negedge PHY_CLKOUT);
        chk($sformatf("rnd%0d_quiet", it), 16'(bus.notify_pending_o), 16'h0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
